// File: rtl/matrix_pkg.sv
// Shared types and widths for the matrix add/subtract sequencer.
// Optional feature macro used by this slice: MATRIX_ADDSUB_ABORT_EN.
package matrix_pkg;

    localparam int ELEM_W = 4;
    localparam int RES_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Element index width; a 1x1 matrix still needs a 1-bit counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_addsub_seq_if.sv
// Operand/result bus of the matrix add/subtract sequencer.
// MATRIX_ADDSUB_ABORT_EN adds the abort request line.
interface matrix_addsub_seq_if #(
    parameter int ROWS = 2,
    parameter int COLS = 2
);
    import matrix_pkg::*;

    localparam int N = ROWS * COLS;

    // Handshake: start is a request taken only while idle, together with op,
    // a_flat and b_flat; busy covers RUN and DONE; done is a one-cycle pulse
    // after which c_flat stays stable until the next accepted start.
    logic                  start;
    logic                  op;
    logic [ELEM_W*N-1:0]   a_flat;
    logic [ELEM_W*N-1:0]   b_flat;
    logic [RES_W*N-1:0]    c_flat;
    logic                  busy;
    logic                  done;
`ifdef MATRIX_ADDSUB_ABORT_EN
    logic                  abort;

    modport master (
        output start, op, a_flat, b_flat, abort,
        input  c_flat, busy, done
    );

    modport slave (
        input  start, op, a_flat, b_flat, abort,
        output c_flat, busy, done
    );
`else
    modport master (
        output start, op, a_flat, b_flat,
        input  c_flat, busy, done
    );

    modport slave (
        input  start, op, a_flat, b_flat,
        output c_flat, busy, done
    );
`endif

endinterface

// File: rtl/AdderSubtractor.sv
// Shared 4-bit adder/subtractor datapath with a 5-bit result.
// Add: bit 4 is the carry. Sub: 5-bit two's complement, bit 4 set iff A < B.
module AdderSubtractor
    import matrix_pkg::*;
(
    input  logic [ELEM_W-1:0] A,
    input  logic [ELEM_W-1:0] B,
    input  logic              Op,
    output logic [RES_W-1:0]  S
);

    always_comb begin
        S = '0;
        if (Op) begin
            S = {1'b0, A} - {1'b0, B};
        end else begin
            S = {1'b0, A} + {1'b0, B};
        end
    end

endmodule

// File: rtl/matrix_addsub_seq.sv
// Element-serial matrix add/subtract: one shared AdderSubtractor, one element per cycle.
// MATRIX_ADDSUB_ABORT_EN adds an abort request honoured only in RUN.
module matrix_addsub_seq
    import matrix_pkg::*;
#(
    parameter int ROWS = 2,
    parameter int COLS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    matrix_addsub_seq_if.slave bus,
    output state_t             state_dbg
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = idx_width(N);
    localparam int AW    = ELEM_W * N;
    localparam int CW    = RES_W * N;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [AW-1:0]      a_q, a_d;
    logic [AW-1:0]      b_q, b_d;
    logic               op_q, op_d;
    logic [CW-1:0]      c_q, c_d;

    logic [ELEM_W-1:0]  a_sel;
    logic [ELEM_W-1:0]  b_sel;
    logic [RES_W-1:0]   sum;
    logic               last_elem;
    logic               abort_req;

`ifdef MATRIX_ADDSUB_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // Operands come only from the latched copies, so bus changes mid-run are invisible.
    assign a_sel     = a_q[int'(idx_q)*ELEM_W +: ELEM_W];
    assign b_sel     = b_q[int'(idx_q)*ELEM_W +: ELEM_W];
    assign last_elem = (idx_q == IDX_W'(N - 1));

    AdderSubtractor u_addsub (
        .A  (a_sel),
        .B  (b_sel),
        .Op (op_q),
        .S  (sum)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        c_d     = c_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a_flat;
                    b_d     = bus.b_flat;
                    op_d    = bus.op;
                    c_d     = '0;
                    idx_d   = '0;
                end
            end
            RUN: begin
                // The element addressed this cycle is written even when aborting.
                c_d[int'(idx_q)*RES_W +: RES_W] = sum;
                if (abort_req) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (last_elem) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            c_q     <= c_d;
        end
    end

    assign bus.c_flat = c_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Self-checking bench for matrix_addsub_seq (2x2); abort cases need MATRIX_ADDSUB_ABORT_EN.
module tb_matrix_addsub_seq;
    import matrix_pkg::*;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [19:0] c;
    } vec_t;

    logic   clk;
    logic   rst_n;
    state_t state_dbg;

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;

    logic [19:0] exp_q[$];
    vec_t        vecs[4];

    matrix_addsub_seq_if #(.ROWS(2), .COLS(2)) bus ();

    matrix_addsub_seq #(.ROWS(2), .COLS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pops one expected result.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, required done=0");
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                check("c_flat", 32'(bus.c_flat), 32'(e));
            end
        end
    end

    function automatic logic [19:0] model(input logic o, input logic [15:0] a, input logic [15:0] b);
        logic [19:0] c;
        int r;
        c = '0;
        for (int k = 0; k < 4; k++) begin
            r = o ? (int'(a[4*k +: 4]) - int'(b[4*k +: 4])) : (int'(a[4*k +: 4]) + int'(b[4*k +: 4]));
            c[5*k +: 5] = 5'(r & 31);
        end
        return c;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 0;
        while (!bus.done && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Drives one operation; lat counts edges from the start-sampling edge to done inclusive.
    task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                          input logic [19:0] exp, output int lat, output int busy_cyc);
        tick(1);
        bus.start  = 1'b1;
        bus.op     = o;
        bus.a_flat = a;
        bus.b_flat = b;
        exp_q.push_back(exp);
        tick(1);
        bus.start = 1'b0;
        lat       = 1;
        busy_cyc  = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_cyc++;
            tick(1);
            lat++;
        end
        if (bus.busy) busy_cyc++;
        tick(1);
    endtask

    initial begin
        int lat, busy_cyc, cyc, d0;
        logic o;
        logic [15:0] ra, rb;

        vecs[0] = '{1'b0, 16'h4321, 16'h1234, {5'd5, 5'd5, 5'd5, 5'd5}};
        vecs[1] = '{1'b1, 16'h4321, 16'h1234, {5'h03, 5'h01, 5'h1F, 5'h1D}};
        vecs[2] = '{1'b0, {4'd8, 4'd7, 4'd0, 4'd15}, {4'd1, 4'd9, 4'd0, 4'd15},
                    {5'd9, 5'd16, 5'd0, 5'h1E}};
        vecs[3] = '{1'b1, {4'd3, 4'd7, 4'd15, 4'd0}, {4'd9, 4'd7, 4'd0, 4'd15},
                    {5'h1A, 5'h00, 5'h0F, 5'h11}};

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 1'b0;
        bus.a_flat = '0;
        bus.b_flat = '0;
`ifdef MATRIX_ADDSUB_ABORT_EN
        bus.abort  = 1'b0;
`endif
        tick(3);
        check("reset_c_flat", 32'(bus.c_flat), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        check("reset_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;
        tick(1);

        // Table-driven vectors
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, lat, busy_cyc);
            check($sformatf("latency_v%0d", i), 32'(lat), 32'd5);
            check($sformatf("busy_cycles_v%0d", i), 32'(busy_cyc), 32'd5);
            check($sformatf("idle_after_v%0d", i), 32'(bus.busy), 32'h0);
        end

        // Random operations against the model
        for (int i = 0; i < 6; i++) begin
            o  = 1'($urandom_range(0, 1));
            ra = '0;
            rb = '0;
            for (int k = 0; k < 4; k++) begin
                ra[4*k +: 4] = 4'($urandom_range(0, 15));
                rb[4*k +: 4] = 4'($urandom_range(0, 15));
            end
            run_op(o, ra, rb, model(o, ra, rb), lat, busy_cyc);
            check($sformatf("latency_rand%0d", i), 32'(lat), 32'd5);
        end

        // Start re-pulsed and operands changed during RUN: ignored
        d0 = done_cnt;
        tick(1);
        bus.start = 1'b1; bus.op = vecs[0].op; bus.a_flat = vecs[0].a; bus.b_flat = vecs[0].b;
        exp_q.push_back(vecs[0].c);
        tick(1);
        bus.start = 1'b0;
        tick(1);
        bus.start = 1'b1; bus.op = 1'b1; bus.a_flat = 16'hFFFF;
        tick(1);
        bus.start = 1'b0;
        wait_done(20, cyc);
        check("ignored_start_done_wait", 32'(cyc), 32'd2);
        tick(8);
        check("ignored_start_one_done", 32'(done_cnt - d0), 32'd1);

        // Back-to-back with start held through DONE
        tick(1);
        bus.start = 1'b1; bus.op = vecs[0].op; bus.a_flat = vecs[0].a; bus.b_flat = vecs[0].b;
        exp_q.push_back(vecs[0].c);
        tick(1);
        bus.op = vecs[3].op; bus.a_flat = vecs[3].a; bus.b_flat = vecs[3].b;
        exp_q.push_back(vecs[3].c);
        wait_done(20, cyc);
        check("b2b_first_done", 32'(cyc), 32'd4);
        tick(1);
        check("b2b_idle_after_done", 32'(state_dbg), 32'(IDLE));
        tick(1);
        check("b2b_accept", 32'(state_dbg), 32'(RUN));
        bus.start = 1'b0;
        wait_done(20, cyc);
        check("b2b_period", 32'(cyc + 2), 32'd6);
        tick(2);

        // Synchronous reset during RUN
        d0 = done_cnt;
        tick(1);
        bus.start = 1'b1; bus.op = vecs[1].op; bus.a_flat = vecs[1].a; bus.b_flat = vecs[1].b;
        tick(1);
        bus.start = 1'b0;
        tick(2);
        check("partial_c_flat", 32'(bus.c_flat), 32'({5'h0, 5'h0, 5'h1F, 5'h1D}));
        rst_n = 1'b0;
        tick(1);
        check("mid_reset_c_flat", 32'(bus.c_flat), 32'h0);
        check("mid_reset_busy", 32'(bus.busy), 32'h0);
        check("mid_reset_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;
        tick(8);
        check("mid_reset_no_done", 32'(done_cnt - d0), 32'd0);
        run_op(vecs[2].op, vecs[2].a, vecs[2].b, vecs[2].c, lat, busy_cyc);
        check("after_reset_latency", 32'(lat), 32'd5);

`ifdef MATRIX_ADDSUB_ABORT_EN
        // Abort in the second RUN cycle keeps the two written elements
        d0 = done_cnt;
        tick(1);
        bus.start = 1'b1; bus.op = vecs[0].op; bus.a_flat = vecs[0].a; bus.b_flat = vecs[0].b;
        tick(1);
        bus.start = 1'b0;
        tick(1);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        check("abort_state", 32'(state_dbg), 32'(IDLE));
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_c_flat", 32'(bus.c_flat), 32'({5'd0, 5'd0, 5'd5, 5'd5}));
        tick(8);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_op(vecs[1].op, vecs[1].a, vecs[1].b, vecs[1].c, lat, busy_cyc);
        check("after_abort_latency", 32'(lat), 32'd5);
`endif

        tick(2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
